// File: rtl/i2c_reg_mailbox.sv
// I2C register map plus two byte FIFOs (i2c2host, host2i2c) between the I2C slave interface and the host.
// Optional macro I2C_MBOX_ERR_IRQ_EN: when defined, irq_o also reflects a non-zero ERR register.
module i2c_reg_mailbox #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  MBOX_ID    = 8'hDA
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] i2c_reg_addr_i,
  input  logic [7:0] i2c_reg_wdata_i,
  input  logic       i2c_reg_wrenable_i,
  output logic [7:0] i2c_reg_rddata_o,
  input  logic       i2c_reg_rd_byte_complete_i,
  input  logic [7:0] host_wdata_i,
  input  logic       host_wvalid_i,
  output logic       host_wready_o,
  output logic [7:0] host_rdata_o,
  output logic       host_rvalid_o,
  input  logic       host_rready_i,
  output logic       irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [7:0] ADDR_ID      = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_SCRATCH = 8'h02;
  localparam logic [7:0] ADDR_ERR     = 8'h03;
  localparam logic [7:0] ADDR_I2H     = 8'h10;
  localparam logic [7:0] ADDR_H2I     = 8'h11;

  logic [7:0]    i2h_mem [FIFO_DEPTH];
  logic [AW-1:0] i2h_wr_ptr;
  logic [AW-1:0] i2h_rd_ptr;
  logic [CW-1:0] i2h_cnt;

  logic [7:0]    h2i_mem [FIFO_DEPTH];
  logic [AW-1:0] h2i_wr_ptr;
  logic [AW-1:0] h2i_rd_ptr;
  logic [CW-1:0] h2i_cnt;

  logic [7:0] scratch;
  logic [1:0] err;
  logic       irq;

  logic       i2h_full, i2h_empty, h2i_full, h2i_empty;
  logic       wr_i2h, i2h_push, i2h_pop;
  logic       h2i_rd_done, h2i_push, h2i_pop;
  logic [1:0] err_set, err_clr, err_next;
  logic [4:0] h2i_cnt_ext;
  logic [3:0] h2i_cnt_sat;
  logic [7:0] status;
  logic [7:0] h2i_head;
  logic       irq_next;

  assign i2h_full  = (i2h_cnt == FULL_CNT);
  assign i2h_empty = (i2h_cnt == '0);
  assign h2i_full  = (h2i_cnt == FULL_CNT);
  assign h2i_empty = (h2i_cnt == '0);

  // Full/empty decisions use pre-cycle occupancy, so a pop in the same cycle never frees room for a push.
  assign wr_i2h      = i2c_reg_wrenable_i && (i2c_reg_addr_i == ADDR_I2H);
  assign i2h_push    = wr_i2h && !i2h_full;
  assign i2h_pop     = !i2h_empty && host_rready_i;
  assign h2i_push    = host_wvalid_i && !h2i_full;
  assign h2i_rd_done = i2c_reg_rd_byte_complete_i && (i2c_reg_addr_i == ADDR_H2I);
  assign h2i_pop     = h2i_rd_done && !h2i_empty;

  assign err_set  = {h2i_rd_done && h2i_empty, wr_i2h && i2h_full};
  assign err_clr  = (i2c_reg_wrenable_i && (i2c_reg_addr_i == ADDR_ERR)) ? i2c_reg_wdata_i[1:0] : 2'b00;
  assign err_next = (err & ~err_clr) | err_set;

  assign h2i_cnt_ext = 5'(h2i_cnt);
  assign h2i_cnt_sat = h2i_cnt_ext[4] ? 4'hF : h2i_cnt_ext[3:0];
  assign status      = {h2i_cnt_sat, h2i_empty, h2i_full, i2h_empty, i2h_full};
  assign h2i_head    = h2i_empty ? 8'hFF : h2i_mem[h2i_rd_ptr];

`ifdef I2C_MBOX_ERR_IRQ_EN
  assign irq_next = !i2h_empty || (err != 2'b00);
`else
  assign irq_next = !i2h_empty;
`endif

  always_comb begin
    i2c_reg_rddata_o = 8'h00;
    case (i2c_reg_addr_i)
      ADDR_ID:      i2c_reg_rddata_o = MBOX_ID;
      ADDR_STATUS:  i2c_reg_rddata_o = status;
      ADDR_SCRATCH: i2c_reg_rddata_o = scratch;
      ADDR_ERR:     i2c_reg_rddata_o = {6'b0, err};
      ADDR_H2I:     i2c_reg_rddata_o = h2i_head;
      default:      i2c_reg_rddata_o = 8'h00;
    endcase
  end

  // Storage arrays carry no reset; occupancy counters guard every read.
  always_ff @(posedge clk_i) begin
    if (i2h_push) i2h_mem[i2h_wr_ptr] <= i2c_reg_wdata_i;
    if (h2i_push) h2i_mem[h2i_wr_ptr] <= host_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      i2h_wr_ptr <= '0;
      i2h_rd_ptr <= '0;
      i2h_cnt    <= '0;
      h2i_wr_ptr <= '0;
      h2i_rd_ptr <= '0;
      h2i_cnt    <= '0;
      scratch    <= 8'h00;
      err        <= 2'b00;
      irq        <= 1'b0;
    end else begin
      if (i2h_push) i2h_wr_ptr <= i2h_wr_ptr + AW'(1);
      if (i2h_pop)  i2h_rd_ptr <= i2h_rd_ptr + AW'(1);
      if (i2h_push && !i2h_pop)      i2h_cnt <= i2h_cnt + CW'(1);
      else if (!i2h_push && i2h_pop) i2h_cnt <= i2h_cnt - CW'(1);

      if (h2i_push) h2i_wr_ptr <= h2i_wr_ptr + AW'(1);
      if (h2i_pop)  h2i_rd_ptr <= h2i_rd_ptr + AW'(1);
      if (h2i_push && !h2i_pop)      h2i_cnt <= h2i_cnt + CW'(1);
      else if (!h2i_push && h2i_pop) h2i_cnt <= h2i_cnt - CW'(1);

      if (i2c_reg_wrenable_i && (i2c_reg_addr_i == ADDR_SCRATCH)) scratch <= i2c_reg_wdata_i;
      err <= err_next;
      irq <= irq_next;
    end
  end

  assign host_wready_o = !h2i_full;
  assign host_rvalid_o = !i2h_empty;
  assign host_rdata_o  = i2h_empty ? 8'h00 : i2h_mem[i2h_rd_ptr];
  assign irq_o         = irq;

endmodule

// File: tb/tb_i2c_reg_mailbox.sv
// Scoreboard bench for i2c_reg_mailbox: queue models of both FIFOs plus SCRATCH/ERR mirror.
module tb_i2c_reg_mailbox;
  localparam int FD = 8;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] i2c_reg_addr_i;
  logic [7:0] i2c_reg_wdata_i;
  logic       i2c_reg_wrenable_i;
  logic [7:0] i2c_reg_rddata_o;
  logic       i2c_reg_rd_byte_complete_i;
  logic [7:0] host_wdata_i;
  logic       host_wvalid_i;
  logic       host_wready_o;
  logic [7:0] host_rdata_o;
  logic       host_rvalid_o;
  logic       host_rready_i;
  logic       irq_o;

  i2c_reg_mailbox #(.FIFO_DEPTH(FD), .MBOX_ID(8'hDA)) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .i2c_reg_addr_i(i2c_reg_addr_i),
    .i2c_reg_wdata_i(i2c_reg_wdata_i),
    .i2c_reg_wrenable_i(i2c_reg_wrenable_i),
    .i2c_reg_rddata_o(i2c_reg_rddata_o),
    .i2c_reg_rd_byte_complete_i(i2c_reg_rd_byte_complete_i),
    .host_wdata_i(host_wdata_i),
    .host_wvalid_i(host_wvalid_i),
    .host_wready_o(host_wready_o),
    .host_rdata_o(host_rdata_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rready_i(host_rready_i),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] i2h_q[$];
  logic [7:0] h2i_q[$];
  logic [7:0] m_scratch;
  logic [1:0] m_err;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    logic [3:0] sat;
    sat = (h2i_q.size() > 15) ? 4'hF : 4'(h2i_q.size());
    return {sat, h2i_q.size() == 0, h2i_q.size() == FD, i2h_q.size() == 0, i2h_q.size() == FD};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] addr);
    case (addr)
      8'h00:   return 8'hDA;
      8'h01:   return exp_status();
      8'h02:   return m_scratch;
      8'h03:   return {6'b0, m_err};
      8'h11:   return (h2i_q.size() == 0) ? 8'hFF : h2i_q[0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic exp_irq();
`ifdef I2C_MBOX_ERR_IRQ_EN
    return (i2h_q.size() != 0) || (m_err != 2'b00);
`else
    return i2h_q.size() != 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic i2c_write(input logic [7:0] addr, input logic [7:0] data);
    i2c_reg_addr_i     = addr;
    i2c_reg_wdata_i    = data;
    i2c_reg_wrenable_i = 1'b1;
    tick();
    i2c_reg_wrenable_i = 1'b0;
    $display("i2c write addr=%02h data=%02h", addr, data);
    if (addr == 8'h02) m_scratch = data;
    if (addr == 8'h03) m_err = m_err & ~data[1:0];
    if (addr == 8'h10) begin
      if (i2h_q.size() == FD) m_err[0] = 1'b1;
      else i2h_q.push_back(data);
    end
  endtask

  task automatic i2c_read(input string tag, input logic [7:0] addr);
    i2c_reg_addr_i = addr;
    #1;
    $display("i2c read  addr=%02h data=%02h", addr, i2c_reg_rddata_o);
    check_eq(tag, i2c_reg_rddata_o, exp_rd(addr));
  endtask

  task automatic rd_complete();
    i2c_reg_addr_i             = 8'h11;
    i2c_reg_rd_byte_complete_i = 1'b1;
    tick();
    i2c_reg_rd_byte_complete_i = 1'b0;
    $display("i2c rd_byte_complete at 11");
    if (h2i_q.size() == 0) m_err[1] = 1'b1;
    else void'(h2i_q.pop_front());
  endtask

  task automatic host_pop(input string tag);
    if (i2h_q.size() == 0) begin
      check_eq({tag, "_rvalid"}, {7'b0, host_rvalid_o}, 8'h00);
    end else begin
      check_eq({tag, "_rvalid"}, {7'b0, host_rvalid_o}, 8'h01);
      check_eq({tag, "_rdata"}, host_rdata_o, i2h_q[0]);
      host_rready_i = 1'b1;
      tick();
      host_rready_i = 1'b0;
      $display("host pop data=%02h", i2h_q[0]);
      void'(i2h_q.pop_front());
    end
  endtask

  task automatic host_push(input logic [7:0] data);
    check_eq("wready", {7'b0, host_wready_o}, {7'b0, h2i_q.size() != FD});
    host_wdata_i  = data;
    host_wvalid_i = 1'b1;
    tick();
    host_wvalid_i = 1'b0;
    $display("host push data=%02h", data);
    if (h2i_q.size() != FD) h2i_q.push_back(data);
  endtask

  // Host pop and I2C write to 0x10 in the same cycle.
  task automatic simul(input logic [7:0] data);
    bit pre_full;
    pre_full = (i2h_q.size() == FD);
    check_eq("simul_head", host_rdata_o, i2h_q[0]);
    i2c_reg_addr_i     = 8'h10;
    i2c_reg_wdata_i    = data;
    i2c_reg_wrenable_i = 1'b1;
    host_rready_i      = 1'b1;
    tick();
    i2c_reg_wrenable_i = 1'b0;
    host_rready_i      = 1'b0;
    $display("simul pop+write data=%02h", data);
    void'(i2h_q.pop_front());
    if (pre_full) m_err[0] = 1'b1;
    else i2h_q.push_back(data);
  endtask

  task automatic check_irq(input string tag);
    tick();
    check_eq(tag, {7'b0, irq_o}, {7'b0, exp_irq()});
  endtask

  task automatic drain(input string tag);
    while (i2h_q.size() != 0) host_pop(tag);
    host_pop({tag, "_empty"});
  endtask

  initial begin
    rstn_i = 1'b0;
    i2c_reg_addr_i = 8'h00;
    i2c_reg_wdata_i = 8'h00;
    i2c_reg_wrenable_i = 1'b0;
    i2c_reg_rd_byte_complete_i = 1'b0;
    host_wdata_i = 8'h00;
    host_wvalid_i = 1'b0;
    host_rready_i = 1'b0;
    m_scratch = 8'h00;
    m_err = 2'b00;
    tick();
    tick();
    rstn_i = 1'b1;
    tick();

    // reset state
    i2c_read("rst_id", 8'h00);
    i2c_read("rst_status", 8'h01);
    check_eq("rst_status_const", i2c_reg_rddata_o, 8'h0A);
    check_eq("rst_wready", {7'b0, host_wready_o}, 8'h01);
    check_eq("rst_rvalid", {7'b0, host_rvalid_o}, 8'h00);
    check_eq("rst_rdata", host_rdata_o, 8'h00);
    check_eq("rst_irq", {7'b0, irq_o}, 8'h00);

    // scratch and unmapped address
    i2c_write(8'h02, 8'hA5);
    i2c_read("scratch", 8'h02);
    i2c_write(8'h05, 8'h33);
    i2c_read("unmapped", 8'h05);
    i2c_read("write_only_10", 8'h10);

    // fill i2c2host past full
    i2c_write(8'h10, 8'h01);
    check_eq("irq_lag", {7'b0, irq_o}, 8'h00);
    check_irq("irq_first_push");
    for (int i = 2; i <= 9; i++) begin
      i2c_write(8'h10, 8'(i));
      if (i == 8) i2c_read("status_full", 8'h01);
    end
    i2c_read("err_overflow", 8'h03);
    drain("pop_order");
    i2c_write(8'h03, 8'h01);
    i2c_read("err_w1c", 8'h03);
    check_irq("irq_drained");

    // host2i2c path
    host_push(8'h11);
    host_push(8'h22);
    i2c_read("status_h2i2", 8'h01);
    i2c_read("h2i_head0", 8'h11);
    rd_complete();
    i2c_read("h2i_head1", 8'h11);
    rd_complete();
    i2c_read("h2i_empty", 8'h11);
    rd_complete();
    i2c_read("err_underflow", 8'h03);
    check_irq("irq_err_only");
    rd_complete();
    i2c_write(8'h03, 8'h02);
    i2c_read("err_clr1", 8'h03);
    i2c_write(8'h03, 8'h00);
    i2c_read("err_kept", 8'h03);

    // same-cycle push/pop with 3 entries, then at full
    for (int i = 0; i < 3; i++) i2c_write(8'h10, 8'h40 + 8'(i));
    simul(8'h44);
    i2c_read("simul3_status", 8'h01);
    i2c_read("simul3_err", 8'h03);
    drain("simul3_order");
    for (int i = 0; i < FD; i++) i2c_write(8'h10, 8'h50 + 8'(i));
    simul(8'h5F);
    i2c_read("simul_full_status", 8'h01);
    i2c_read("simul_full_err", 8'h03);
    drain("simul_full_order");
    i2c_write(8'h03, 8'h03);

    // asynchronous reset with 5 queued entries and ERR=0x03
    for (int i = 0; i < FD + 1; i++) i2c_write(8'h10, 8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) host_pop("pre_rst_pop");
    rd_complete();
    i2c_read("pre_rst_err", 8'h03);
    check_eq("pre_rst_err_const", i2c_reg_rddata_o, 8'h03);
    check_irq("pre_rst_irq");
    host_push(8'h77);
    #2;
    rstn_i = 1'b0;
    #1;
    i2h_q.delete();
    h2i_q.delete();
    m_err = 2'b00;
    m_scratch = 8'h00;
    $display("async reset asserted");
    check_eq("rst_mid_irq", {7'b0, irq_o}, 8'h00);
    check_eq("rst_mid_rvalid", {7'b0, host_rvalid_o}, 8'h00);
    check_eq("rst_mid_rdata", host_rdata_o, 8'h00);
    check_eq("rst_mid_wready", {7'b0, host_wready_o}, 8'h01);
    i2c_read("rst_mid_status", 8'h01);
    i2c_read("rst_mid_err", 8'h03);
    i2c_read("rst_mid_scratch", 8'h02);
    tick();
    rstn_i = 1'b1;
    tick();
    i2c_read("post_rst_id", 8'h00);
    i2c_read("post_rst_h2i", 8'h11);
    check_irq("post_rst_irq");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
